// File: rtl/exu_muldiv_ctrl_pkg.sv
// rtl/exu_muldiv_ctrl_pkg.sv - shared op codes and state encoding for the mul/div EX controller
package exu_muldiv_ctrl_pkg;

    localparam logic [3:0] MUL_OP_MUL    = 4'b0001;
    localparam logic [3:0] MUL_OP_MULH   = 4'b0010;
    localparam logic [3:0] MUL_OP_MULHSU = 4'b0100;
    localparam logic [3:0] MUL_OP_MULHU  = 4'b1000;

    localparam logic [3:0] DIV_OP_DIV  = 4'b0001;
    localparam logic [3:0] DIV_OP_DIVU = 4'b0010;
    localparam logic [3:0] DIV_OP_REM  = 4'b0100;
    localparam logic [3:0] DIV_OP_REMU = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_WB       = 2'd3
    } ctrl_state_e;

    // Quotient ops return all-ones on a zero divisor; remainder ops return the dividend.
    function automatic logic div_op_is_quot(input logic [3:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_DIVU);
    endfunction

endpackage

// File: rtl/exu_muldiv_ctrl.sv
// rtl/exu_muldiv_ctrl.sv - EX-stage start/ready initiator for the iterative mul/div units
// Optional DIV_ZERO_BYPASS_EN: divide by zero skips the divider and writes back directly.
module exu_muldiv_ctrl
    import exu_muldiv_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    input  logic          req_is_div_i,
    input  logic [3:0]    req_op_i,
    input  logic [DW-1:0] rs1_i,
    input  logic [DW-1:0] rs2_i,
    input  logic [AW-1:0] rd_i,
    input  logic          flush_i,
    output logic          stall_o,
    output logic          mul_start_o,
    output logic [3:0]    mul_op_o,
    output logic [DW-1:0] mul_a_o,
    output logic [DW-1:0] mul_b_o,
    output logic [AW-1:0] mul_waddr_o,
    input  logic [DW-1:0] mul_result_i,
    input  logic          mul_ready_i,
    output logic          div_start_o,
    output logic [3:0]    div_op_o,
    output logic [DW-1:0] div_a_o,
    output logic [DW-1:0] div_b_o,
    output logic [AW-1:0] div_waddr_o,
    input  logic [DW-1:0] div_result_i,
    input  logic          div_ready_i,
    output logic          wb_valid_o,
    input  logic          wb_ready_i,
    output logic [AW-1:0] wb_waddr_o,
    output logic [DW-1:0] wb_data_o
);

    ctrl_state_e   state_q;
    logic          first_q;
    logic          mul_start_q;
    logic [3:0]    mul_op_q;
    logic [DW-1:0] mul_a_q;
    logic [DW-1:0] mul_b_q;
    logic [AW-1:0] mul_waddr_q;
    logic          div_start_q;
    logic [3:0]    div_op_q;
    logic [DW-1:0] div_a_q;
    logic [DW-1:0] div_b_q;
    logic [AW-1:0] div_waddr_q;
    logic          wb_valid_q;
    logic [AW-1:0] wb_waddr_q;
    logic [DW-1:0] wb_data_q;

    logic req_fire;
    logic mul_done;
    logic div_done;

    // first_q masks ready in the first WAIT cycle so a late pulse from an aborted op is dropped.
    assign req_fire = (state_q == ST_IDLE) && req_valid_i && !flush_i;
    assign mul_done = (state_q == ST_MUL_WAIT) && !first_q && mul_ready_i;
    assign div_done = (state_q == ST_DIV_WAIT) && !first_q && div_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            first_q     <= 1'b0;
            mul_start_q <= 1'b0;
            mul_op_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_waddr_q <= '0;
            div_start_q <= 1'b0;
            div_op_q    <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            div_waddr_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_waddr_q  <= '0;
            wb_data_q   <= '0;
        end else begin
            first_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        if (req_is_div_i) begin
                            div_op_q    <= req_op_i;
                            div_a_q     <= rs1_i;
                            div_b_q     <= rs2_i;
                            div_waddr_q <= rd_i;
`ifdef DIV_ZERO_BYPASS_EN
                            if (rs2_i == '0) begin
                                state_q    <= ST_WB;
                                wb_valid_q <= 1'b1;
                                wb_waddr_q <= rd_i;
                                wb_data_q  <= div_op_is_quot(req_op_i) ? {DW{1'b1}} : rs1_i;
                            end else begin
                                state_q     <= ST_DIV_WAIT;
                                div_start_q <= 1'b1;
                                first_q     <= 1'b1;
                            end
`else
                            state_q     <= ST_DIV_WAIT;
                            div_start_q <= 1'b1;
                            first_q     <= 1'b1;
`endif
                        end else begin
                            mul_op_q    <= req_op_i;
                            mul_a_q     <= rs1_i;
                            mul_b_q     <= rs2_i;
                            mul_waddr_q <= rd_i;
                            state_q     <= ST_MUL_WAIT;
                            mul_start_q <= 1'b1;
                            first_q     <= 1'b1;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (flush_i) begin
                        state_q     <= ST_IDLE;
                        mul_start_q <= 1'b0;
                    end else if (mul_done) begin
                        state_q     <= ST_WB;
                        mul_start_q <= 1'b0;
                        wb_valid_q  <= 1'b1;
                        wb_data_q   <= mul_result_i;
                        wb_waddr_q  <= mul_waddr_q;
                    end
                end
                ST_DIV_WAIT: begin
                    if (flush_i) begin
                        state_q     <= ST_IDLE;
                        div_start_q <= 1'b0;
                    end else if (div_done) begin
                        state_q     <= ST_WB;
                        div_start_q <= 1'b0;
                        wb_valid_q  <= 1'b1;
                        wb_data_q   <= div_result_i;
                        wb_waddr_q  <= div_waddr_q;
                    end
                end
                ST_WB: begin
                    if (flush_i || wb_ready_i) begin
                        state_q    <= ST_IDLE;
                        wb_valid_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        case (state_q)
            ST_IDLE:     stall_o = req_valid_i && !flush_i;
            ST_MUL_WAIT: stall_o = 1'b1;
            ST_DIV_WAIT: stall_o = 1'b1;
            ST_WB:       stall_o = !wb_ready_i;
            default:     stall_o = 1'b0;
        endcase
    end

    assign mul_start_o = mul_start_q;
    assign mul_op_o    = mul_op_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign mul_waddr_o = mul_waddr_q;
    assign div_start_o = div_start_q;
    assign div_op_o    = div_op_q;
    assign div_a_o     = div_a_q;
    assign div_b_o     = div_b_q;
    assign div_waddr_o = div_waddr_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_waddr_o  = wb_waddr_q;
    assign wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_exu_muldiv_ctrl.sv
// tb/tb_exu_muldiv_ctrl.sv - self-checking bench for exu_muldiv_ctrl with behavioural mul/div units
module tb_exu_muldiv_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_is_div_i;
    logic [3:0]  req_op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        mul_start_o;
    logic [3:0]  mul_op_o;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic [4:0]  mul_waddr_o;
    logic [31:0] mul_result_i;
    logic        mul_ready_i;
    logic        div_start_o;
    logic [3:0]  div_op_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic [4:0]  div_waddr_o;
    logic [31:0] div_result_i;
    logic        div_ready_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_data_o;

    int n_checks = 0;
    int n_fails  = 0;

    exu_muldiv_ctrl #(.DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_is_div_i(req_is_div_i), .req_op_i(req_op_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i), .stall_o(stall_o),
        .mul_start_o(mul_start_o), .mul_op_o(mul_op_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_waddr_o(mul_waddr_o), .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
        .div_start_o(div_start_o), .div_op_o(div_op_o), .div_a_o(div_a_o), .div_b_o(div_b_o),
        .div_waddr_o(div_waddr_o), .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_waddr_o(wb_waddr_o),
        .wb_data_o(wb_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input bit is_div, input logic [3:0] op,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        p  = '0;
        if (!is_div) begin
            case (op)
                4'b0001: begin p = ua * ub; r = p[31:0];  end
                4'b0010: begin p = sa * sb; r = p[63:32]; end
                4'b0100: begin p = sa * ub; r = p[63:32]; end
                4'b1000: begin p = ua * ub; r = p[63:32]; end
                default: r = '0;
            endcase
        end else begin
            case (op)
                4'b0001: if (b == 0) r = 32'hFFFF_FFFF;
                         else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                         else r = $signed(a) / $signed(b);
                4'b0010: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                4'b0100: if (b == 0) r = a;
                         else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                         else r = $signed(a) % $signed(b);
                4'b1000: r = (b == 0) ? a : a % b;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // Iterative unit models: IDLE edge, 16 CALC edges, OUTPUT edge raises ready; abort when start drops.
    int mu_st = 0, mu_cnt = 0, du_st = 0, du_cnt = 0;
    initial begin mul_ready_i = 1'b0; div_ready_i = 1'b0; mul_result_i = '0; div_result_i = '0; end

    always @(posedge clk) begin
        mul_ready_i <= 1'b0;
        case (mu_st)
            0: if (mul_start_o) begin mu_st <= 1; mu_cnt <= 0; end
            1: if (!mul_start_o) mu_st <= 0;
               else if (mu_cnt == 15) mu_st <= 2;
               else mu_cnt <= mu_cnt + 1;
            default: begin
                mu_st <= 0;
                if (mul_start_o) begin
                    mul_ready_i  <= 1'b1;
                    mul_result_i <= ref_result(1'b0, mul_op_o, mul_a_o, mul_b_o);
                end
            end
        endcase
    end

    always @(posedge clk) begin
        div_ready_i <= 1'b0;
        case (du_st)
            0: if (div_start_o) begin du_st <= 1; du_cnt <= 0; end
            1: if (!div_start_o) du_st <= 0;
               else if (du_cnt == 15) du_st <= 2;
               else du_cnt <= du_cnt + 1;
            default: begin
                du_st <= 0;
                if (div_start_o) begin
                    div_ready_i  <= 1'b1;
                    div_result_i <= ref_result(1'b1, div_op_o, div_a_o, div_b_o);
                end
            end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input bit is_div, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd);
        req_valid_i = 1'b1; req_is_div_i = is_div; req_op_i = op;
        rs1_i = a; rs2_i = b; rd_i = rd;
        check_eq("stall_on_req", stall_o, 1);
        tick;
        req_valid_i = 1'b0; rs1_i = $urandom; rs2_i = $urandom; rd_i = 5'($urandom);
    endtask

    task automatic do_op(input bit is_div, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input int hold);
        bit bypass, stall_ok, start_ok, div_seen, mul_seen;
        int k;
        logic [31:0] exp_data, d0;
        logic [4:0]  w0;
        bypass = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
        bypass = is_div && (b == 0);
`endif
        exp_data = ref_result(is_div, op, a, b);
        stall_ok = 1'b1; start_ok = 1'b1; div_seen = 1'b0; mul_seen = 1'b0; k = 0;
        wb_ready_i = (hold == 0);
        start_op(is_div, op, a, b, rd);
        if (!bypass) begin
            if (is_div) check_eq("div_regs", {div_op_o, div_a_o, div_b_o, div_waddr_o}, {op, a, b, rd});
            else        check_eq("mul_regs", {mul_op_o, mul_a_o, mul_b_o, mul_waddr_o}, {op, a, b, rd});
        end
        while (!wb_valid_o && k < 100) begin
            if (!stall_o) stall_ok = 1'b0;
            if (is_div ? !div_start_o : !mul_start_o) start_ok = 1'b0;
            if (div_start_o) div_seen = 1'b1;
            if (mul_start_o) mul_seen = 1'b1;
            tick;
            k++;
        end
        check_eq("wb_valid", wb_valid_o, 1);
        check_eq("latency", k, bypass ? 0 : 19);
        if (!bypass) begin
            check_eq("stall_in_wait", stall_ok, 1);
            check_eq("start_held", start_ok, 1);
            check_eq("other_start_low", is_div ? mul_seen : div_seen, 0);
        end
        if (bypass) check_eq("div_start_never", div_seen | div_start_o, 0);
        check_eq("start_dropped", {mul_start_o, div_start_o}, 0);
        check_eq("wb_data", wb_data_o, exp_data);
        check_eq("wb_waddr", wb_waddr_o, rd);
        d0 = wb_data_o; w0 = wb_waddr_o;
        for (int i = 0; i < hold; i++) begin
            check_eq("stall_wb_hold", stall_o, 1);
            tick;
            check_eq("wb_hold_valid", wb_valid_o, 1);
            check_eq("wb_hold_stable", {wb_data_o, wb_waddr_o}, {d0, w0});
        end
        wb_ready_i = 1'b1;
        check_eq("stall_wb_accept", stall_o, 0);
        tick;
        check_eq("wb_single_pulse", wb_valid_o, 0);
        req_valid_i = 1'b1; req_is_div_i = 1'b0;
        check_eq("back_to_idle", stall_o, 1);
        req_valid_i = 1'b0;
    endtask

    initial begin
        int k;
        bit seen;
        rst = 1'b1; req_valid_i = 0; req_is_div_i = 0; req_op_i = 0;
        rs1_i = 0; rs2_i = 0; rd_i = 0; flush_i = 0; wb_ready_i = 1;
        tick; tick;
        check_eq("rst_ctrl", {stall_o, mul_start_o, div_start_o, wb_valid_o}, 0);
        check_eq("rst_regs", {mul_op_o, mul_a_o, mul_b_o, mul_waddr_o, div_op_o, div_a_o}, 0);
        check_eq("rst_wb", {wb_data_o, wb_waddr_o, div_b_o, div_waddr_o}, 0);
        rst = 1'b0;
        tick;

        do_op(0, 4'b0001, 32'd7, 32'hFFFF_FFFD, 5'd5, 0);
        do_op(0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 3);

        // flush five cycles into a MULH
        start_op(0, 4'b0010, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3);
        for (int i = 0; i < 4; i++) tick;
        flush_i = 1'b1; tick; flush_i = 1'b0;
        check_eq("flush_wait_start", mul_start_o, 0);
        check_eq("flush_wait_stall", stall_o, 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin if (wb_valid_o) seen = 1'b1; tick; end
        check_eq("flush_no_wb", seen, 0);
        do_op(0, 4'b0001, 32'd3, 32'd4, 5'd7, 0);

        // flush on the unit's OUTPUT cycle, then an immediate MUL
        start_op(0, 4'b0001, 32'd11, 32'd13, 5'd4);
        k = 0;
        while (mu_st != 2 && k < 40) begin tick; k++; end
        check_eq("unit_reached_output", mu_st, 2);
        flush_i = 1'b1; tick; flush_i = 1'b0;
        check_eq("flush_out_no_wb", wb_valid_o, 0);
        do_op(0, 4'b0001, 32'd2, 32'd2, 5'd8, 1);

        // divide by zero
        do_op(1, 4'b0010, 32'd100, 32'd0, 5'd12, 0);
        do_op(1, 4'b0100, 32'd55, 32'd0, 5'd13, 2);

        // reset mid-WAIT
        start_op(0, 4'b0001, 32'd9, 32'd9, 5'd1);
        for (int i = 0; i < 5; i++) tick;
        rst = 1'b1; tick;
        check_eq("rst_mid_ctrl", {stall_o, mul_start_o, div_start_o, wb_valid_o}, 0);
        check_eq("rst_mid_regs", {mul_op_o, mul_a_o, mul_b_o, mul_waddr_o}, 0);
        rst = 1'b0; tick;
        do_op(1, 4'b0100, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);

        // flush in IDLE blocks the request; flush in WB drops the result
        req_valid_i = 1'b1; req_is_div_i = 1'b0; req_op_i = 4'b0001; flush_i = 1'b1;
        check_eq("flush_idle_stall", stall_o, 0);
        tick; req_valid_i = 1'b0; flush_i = 1'b0;
        check_eq("flush_idle_no_start", mul_start_o, 0);
        wb_ready_i = 1'b0;
        start_op(0, 4'b0001, 32'd5, 32'd5, 5'd2);
        k = 0;
        while (!wb_valid_o && k < 40) begin tick; k++; end
        check_eq("wb_before_flush", wb_valid_o, 1);
        flush_i = 1'b1; tick; flush_i = 1'b0; wb_ready_i = 1'b1;
        check_eq("flush_wb_cleared", wb_valid_o, 0);
        tick;

        do_op(1, 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        for (int n = 0; n < 40; n++) begin
            bit          is_div;
            logic [3:0]  op;
            logic [31:0] a, b;
            is_div = 1'($urandom);
            op     = 4'(1 << ($urandom % 4));
            a      = $urandom;
            b      = ($urandom % 6 == 0) ? 32'd0 : (($urandom % 3 == 0) ? ($urandom % 17) : $urandom);
            do_op(is_div, op, a, b, 5'($urandom), int'($urandom % 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/exu_muldiv_ctrl.md
Name: exu_muldiv_ctrl

Overview:
- EX-stage initiator for the iterative multiply and divide units. It owns the start/ready/busy handshake that those units respond to.
- Accepts one M-extension op from EX, registers the operands, and holds the unit's start line until ready.
- Captures the result and presents it to the regfile write port through a valid/ready handshake.
- Stalls the pipeline while an op is in flight.

Parameters:
- DW, 32, data width; matches REG_DATA_WIDTH.
- AW, 5, register address width; matches REG_ADDR_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high (RstEnable)
- req_valid_i  in  1  EX presents a mul/div op
- req_is_div_i  in  1  1 = divide unit, 0 = multiply unit
- req_op_i  in  4  one-hot; mul: 0001 MUL, 0010 MULH, 0100 MULHSU, 1000 MULHU; div: 0001 DIV, 0010 DIVU, 0100 REM, 1000 REMU
- rs1_i  in  DW  multiplicand / dividend
- rs2_i  in  DW  multiplier / divisor
- rd_i  in  AW  destination register
- flush_i  in  1  pipeline flush; cancels the in-flight op
- stall_o  out  1  hold EX/ID
- mul_start_o  out  1  held high until mul_ready_i
- mul_op_o  out  4  registered op
- mul_a_o, mul_b_o  out  DW  registered operands
- mul_waddr_o  out  AW  registered rd
- mul_result_i  in  DW  multiply result
- mul_ready_i  in  1  one-cycle done pulse
- div_start_o  out  1  divider start
- div_op_o  out  4  registered op
- div_a_o, div_b_o  out  DW  registered operands
- div_waddr_o  out  AW  registered rd
- div_result_i  in  DW  divide result
- div_ready_i  in  1  divider done pulse
- wb_valid_o  out  1  result valid
- wb_ready_i  in  1  regfile port accepts
- wb_waddr_o  out  AW  result destination
- wb_data_o  out  DW  result data

Behaviour:
- Reset: state IDLE. All outputs 0, including both start lines, wb_valid_o and stall_o. The operand registers are also cleared.
- States:
  - IDLE -> MUL_WAIT / DIV_WAIT when req_valid_i && !flush_i. Operands, op and rd are registered on that edge; the start line rises on the same edge.
  - MUL_WAIT / DIV_WAIT -> WB on the ready pulse. Result and rd are captured into wb_data_o / wb_waddr_o, and start drops on that edge.
  - WB -> IDLE when wb_valid_o && wb_ready_i.
- Ready qualification:
  - ready is ignored in IDLE, in WB, and in the first WAIT cycle. This rejects a stale pulse from a previously aborted op.
  - Only the ready of the selected unit counts; a ready from the other unit is ignored.
- Unit restart: the unit may restart for one cycle because start was high at its IDLE edge. This is tolerated; it aborts itself when start drops.
- Latency: a MUL accepted at edge N gives wb_valid_o at edge N+19 (unit: 1 IDLE + 16 CALC + 1 OUTPUT, plus the capture edge). No req is accepted while not IDLE.
- stall_o:
  - combinational (req_valid_i && !flush_i) in IDLE;
  - 1 in both WAIT states;
  - in WB, equals !wb_ready_i.
- wb_* remain stable while wb_valid_o && !wb_ready_i.
- flush_i in WAIT: next state IDLE, start drops, no writeback.
- flush_i in WB: wb_valid_o is cleared and the result discarded.
- flush_i in IDLE: the concurrent req is not accepted.
- Reset mid-operation: returns to IDLE in one cycle and drops start. The unit self-aborts.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: a divide request with rs2_i == 0 skips the divider (div_start_o never rises) and goes IDLE -> WB in one edge.
  - DIV / DIVU return 0xFFFFFFFF.
  - REM / REMU return rs1_i.
- Undefined: all divides go to the divider.

Decomposition:
- Shared package / defines.v holds:
  - mul op one-hot codes MUL_OP_MUL/MULH/MULHSU/MULHU;
  - div op codes DIV_OP_DIV/DIVU/REM/REMU;
  - controller state encodings (2 bits).
- No sub-module. The WB output register is small enough to stay inline.

Test Plan:
- MUL 7 × 0xFFFFFFFD, rd=5, wb_ready_i=1 -> one wb pulse, data 0xFFFFFFEB, waddr 5. The pulse arrives 19 edges after accept, with stall_o high throughout.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF with wb_ready_i held low for 3 cycles -> wb_data_o 0xFFFFFFFE held stable. Return to IDLE on the accept edge.
- flush_i 5 cycles into a MULH -> mul_start_o low next cycle, no wb pulse. A following MUL 3×4 writes 12.
- flush_i coinciding with the unit's OUTPUT cycle, then immediately MUL 2×2 -> the stale ready is ignored and the result is 4.
- DIVU 100 / 0 -> with DIV_ZERO_BYPASS_EN: result 0xFFFFFFFF after 1 edge, div_start_o never high. Without it: the divider is started.
- rst asserted mid-MUL_WAIT -> all outputs 0 next cycle. A fresh REM -7 / 2 then returns 0xFFFFFFFF.
